// File: rtl/bitblock_pkg.sv
// Shared definitions for the bit-serial lane-split MAC core: mode and state
// encodings plus lane-geometry helpers used at elaboration and run time.
package bitblock_pkg;

    typedef enum logic [1:0] {
        MODE_1L  = 2'd0,
        MODE_2L  = 2'd1,
        MODE_4L  = 2'd2,
        MODE_BAD = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WB   = 2'd2
    } state_e;

    function automatic int unsigned lane_width(mode_e mode, int unsigned w);
        case (mode)
            MODE_1L: return w;
            MODE_2L: return w / 2;
            default: return w / 4;
        endcase
    endfunction

    // 1 where accumulator slice `slice` starts a new lane (its carry-in is cut).
    function automatic logic carry_cut(int unsigned slice, mode_e mode,
                                       int unsigned w, int unsigned sw);
        return logic'(((slice * sw) % (2 * lane_width(mode, w))) == 0);
    endfunction

endpackage

// File: rtl/bitblock_slice.sv
// One SW-bit accumulator slice: gated partial-product bits added to the
// accumulator bits with an externally selected carry-in.
module bitblock_slice #(
    parameter int SW = 4
) (
    input  logic [SW-1:0] acc,
    input  logic [SW-1:0] pp,
    input  logic          en,
    input  logic          cin,
    output logic [SW-1:0] sum,
    output logic          cout
);

    logic [SW-1:0] gated;

    assign gated       = pp & {SW{en}};
    assign {cout, sum} = {1'b0, acc} + {1'b0, gated} + {{SW{1'b0}}, cin};

endmodule

// File: rtl/bitblock_mac_core.sv
// Bit-serial multiply-accumulate core with a W-bit datapath split into 1, 2
// or 4 lanes; y is consumed LSB-first, one bit per RUN cycle.
module bitblock_mac_core
    import bitblock_pkg::*;
#(
    parameter int W  = 16,
    parameter int SW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     in_mode,
    input  logic           in_clear,
    input  logic [W-1:0]   in_x,
    input  logic [W-1:0]   in_y,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [2*W-1:0] res_data,
    output logic           busy,
    output logic           err
);

    localparam int AW = 2 * W;
    localparam int NS = AW / SW;
    localparam int P1 = W;
    localparam int P2 = W / 2;
    localparam int P4 = W / 4;
    localparam int CW = $clog2(W);

    state_e          state;
    mode_e           mode_q;
    logic [W-1:0]    x_q;
    logic [W-1:0]    y_q;
    logic [AW-1:0]   acc;
    logic [CW-1:0]   cnt;
    logic            last;

    logic [AW-1:0]   pp;
    logic [AW-1:0]   sum;
    logic [NS-1:0]   en;
    logic [NS-1:0]   carry;
    logic            unused_carry;

    assign last         = (cnt == CW'(lane_width(mode_q, W) - 1));
    assign unused_carry = carry[NS-1];

    // Each lane's x is placed at the bottom of its 2P-bit accumulator lane and
    // shifted by the current bit index; every slice of the lane is gated by
    // that lane's current y bit (the LSB of the lane in the shift register).
    always_comb begin
        pp = '0;
        en = '0;
        case (mode_q)
            MODE_1L: begin
                pp[0 +: 2*P1] = {{P1{1'b0}}, x_q} << cnt;
                for (int unsigned s = 0; s < 2*P1/SW; s++)
                    en[s] = y_q[0];
            end
            MODE_2L: begin
                for (int unsigned k = 0; k < 2; k++) begin
                    pp[2*P2*k +: 2*P2] = {{P2{1'b0}}, x_q[P2*k +: P2]} << cnt;
                    for (int unsigned s = 0; s < 2*P2/SW; s++)
                        en[(2*P2*k)/SW + s] = y_q[P2*k];
                end
            end
            default: begin
                for (int unsigned k = 0; k < 4; k++) begin
                    pp[2*P4*k +: 2*P4] = {{P4{1'b0}}, x_q[P4*k +: P4]} << cnt;
                    for (int unsigned s = 0; s < 2*P4/SW; s++)
                        en[(2*P4*k)/SW + s] = y_q[P4*k];
                end
            end
        endcase
    end

    for (genvar j = 0; j < NS; j++) begin : g_slice
        localparam logic CUT1 = carry_cut(j, MODE_1L, W, SW);
        localparam logic CUT2 = carry_cut(j, MODE_2L, W, SW);
        localparam logic CUT4 = carry_cut(j, MODE_4L, W, SW);

        logic cut;
        logic cin;

        assign cut = (mode_q == MODE_1L) ? CUT1 :
                     (mode_q == MODE_2L) ? CUT2 : CUT4;

        if (j == 0) begin : g_first
            assign cin = 1'b0;
        end else begin : g_chain
            assign cin = cut ? 1'b0 : carry[j-1];
        end

        bitblock_slice #(
            .SW(SW)
        ) u_slice (
            .acc  (acc[SW*j +: SW]),
            .pp   (pp[SW*j +: SW]),
            .en   (en[j]),
            .cin  (cin),
            .sum  (sum[SW*j +: SW]),
            .cout (carry[j])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mode_q    <= MODE_1L;
            x_q       <= '0;
            y_q       <= '0;
            acc       <= '0;
            cnt       <= '0;
            res_data  <= '0;
            res_valid <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            // A consumer handshake drops res_valid unless WB reloads below.
            if (res_valid && res_ready)
                res_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mode_q   <= (in_mode == 2'd3) ? MODE_4L : mode_e'(in_mode);
                        x_q      <= in_x;
                        y_q      <= in_y;
                        cnt      <= '0;
                        if (in_clear)
                            acc <= '0;
                        if (in_mode == 2'd3)
                            err <= 1'b1;
                        state    <= RUN;
                        busy     <= 1'b1;
                        in_ready <= 1'b0;
                    end
                end
                RUN: begin
                    acc <= sum;
                    y_q <= y_q >> 1;
                    cnt <= cnt + 1'b1;
                    if (last)
                        state <= WB;
                end
                WB: begin
                    if (!res_valid || res_ready) begin
                        res_data  <= acc;
                        res_valid <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
